// File: rtl/adc_capture_pkg.sv
// Shared constants, mode enum and sizing helper for the ADC capture block.
package adc_capture_pkg;

    localparam int unsigned DEF_DATA_W   = 16;
    localparam int unsigned DEF_DECIM    = 20001;
    localparam int unsigned DEF_AVG_LOG2 = 4;
    localparam int unsigned DEF_LED_LSB  = 1;
    localparam int unsigned DEF_DROP_W   = 16;

    typedef enum logic {
        MODE_PICK = 1'b0,
        MODE_AVG  = 1'b1
    } mode_e;

    // Width needed for a counter running 0..n-1 (never narrower than 1 bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/adc_capture_avg.sv
// Windowed accumulator: sums the last 2**AVG_LOG2 samples of each window and
// presents the truncated mean combinationally during the window-end cycle.
module adc_capture_avg
    import adc_capture_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned DECIM    = DEF_DECIM,
    parameter int unsigned AVG_LOG2 = DEF_AVG_LOG2,
    parameter int unsigned CNT_W    = cnt_width(DEF_DECIM)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CNT_W-1:0]  cnt_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] avg_c_o
);

    localparam int unsigned ACC_W = DATA_W + AVG_LOG2;
    localparam int unsigned AVG_N = 1 << AVG_LOG2;
    localparam int unsigned START = DECIM - AVG_N;

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W-1:0] sum_c;
    logic             load_c;

    // First averaged sample restarts the sum; the window end sees the full total in sum_c.
    always_comb begin
        load_c  = (cnt_i == CNT_W'(START));
        sum_c   = load_c ? ACC_W'(data_i) : (acc_q + ACC_W'(data_i));
        acc_d   = sum_c;
        avg_c_o = DATA_W'(sum_c >> AVG_LOG2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/adc_capture.sv
// ADC decimator: one output word per DECIM-sample window (pick or average),
// valid/ready output register with drop counting. Average mode needs ADC_CAPTURE_AVG_EN.
module adc_capture
    import adc_capture_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned DECIM    = DEF_DECIM,
    parameter int unsigned AVG_LOG2 = DEF_AVG_LOG2,
    parameter int unsigned LED_LSB  = DEF_LED_LSB,
    parameter int unsigned DROP_W   = DEF_DROP_W
) (
    input  logic              clkouta,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              ofa,
    input  logic              avg_mode,
    output logic [DATA_W-1:0] data_out,
    output logic              data_out_valid,
    input  logic              data_out_ready,
    output logic              data_out_ovr,
    output logic [DROP_W-1:0] drop_cnt,
    output logic [7:0]        LED
);

    localparam int unsigned CNT_W = cnt_width(DECIM);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM - 1);

    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    logic              win_ovr_q, win_ovr_d;
    logic [DATA_W-1:0] out_q,     out_d;
    logic              out_vld_q, out_vld_d;
    logic              out_ovr_q, out_ovr_d;
    logic [DROP_W-1:0] drop_q,    drop_d;

    logic              win_end_c;
    logic              load_c;
    logic              drop_c;
    logic [DATA_W-1:0] result_c;

    assign win_end_c = (cnt_q == CNT_LAST);

`ifdef ADC_CAPTURE_AVG_EN
    mode_e             mode_q, mode_d;
    logic [DATA_W-1:0] avg_c;

    adc_capture_avg #(
        .DATA_W   (DATA_W),
        .DECIM    (DECIM),
        .AVG_LOG2 (AVG_LOG2),
        .CNT_W    (CNT_W)
    ) u_avg (
        .clk     (clkouta),
        .rst_n   (rst_n),
        .cnt_i   (cnt_q),
        .data_i  (data_in),
        .avg_c_o (avg_c)
    );

    // Mode is latched at window start so a mid-window change waits for the next window.
    always_comb begin
        mode_d = mode_q;
        if (cnt_q == '0) begin
            mode_d = mode_e'(avg_mode);
        end
    end

    always_ff @(posedge clkouta or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= MODE_PICK;
        end else begin
            mode_q <= mode_d;
        end
    end

    assign result_c = (mode_q == MODE_AVG) ? avg_c : data_in;
`else
    logic unused_c;

    assign unused_c = avg_mode ^ AVG_LOG2[0];
    assign result_c = data_in;
`endif

    // Window sequencing, over-range tracking and the output handshake register.
    always_comb begin
        cnt_d     = win_end_c ? '0 : (cnt_q + CNT_W'(1));
        win_ovr_d = win_end_c ? 1'b0 : (win_ovr_q | ofa);
        load_c    = win_end_c && (!out_vld_q || data_out_ready);
        drop_c    = win_end_c && out_vld_q && !data_out_ready;

        out_d     = out_q;
        out_ovr_d = out_ovr_q;
        out_vld_d = out_vld_q;
        drop_d    = drop_q;

        if (load_c) begin
            out_d     = result_c;
            out_ovr_d = win_ovr_q | ofa;
            out_vld_d = 1'b1;
        end else if (out_vld_q && data_out_ready) begin
            out_vld_d = 1'b0;
        end

        if (drop_c && (drop_q != '1)) begin
            drop_d = drop_q + DROP_W'(1);
        end
    end

    always_ff @(posedge clkouta or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            win_ovr_q <= 1'b0;
            out_q     <= '0;
            out_vld_q <= 1'b0;
            out_ovr_q <= 1'b0;
            drop_q    <= '0;
        end else begin
            cnt_q     <= cnt_d;
            win_ovr_q <= win_ovr_d;
            out_q     <= out_d;
            out_vld_q <= out_vld_d;
            out_ovr_q <= out_ovr_d;
            drop_q    <= drop_d;
        end
    end

    assign data_out       = out_q;
    assign data_out_valid = out_vld_q;
    assign data_out_ovr   = out_ovr_q;
    assign drop_cnt       = drop_q;
    assign LED            = out_q[LED_LSB +: 8];

endmodule
